// File: rtl/digit_matrix_scanner_pkg.sv
// Shared widths and scan-FSM encoding for the dot-matrix digit scanner.
// Pure declarations: no latency, no flow control.
package digit_matrix_scanner_pkg;

  localparam int SEG_W  = 7;
  localparam int BMP_W  = 5;
  localparam int LINE_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH,
    ST_DWELL
  } state_e;

endpackage

// File: rtl/digit_matrix_scanner_s2b.sv
// Seven-segment code {a,b,c,d,e,f,g} to one 5-pixel line of a 5-line glyph.
// Purely combinational; no flow control.
module segments_to_bitmap
  import digit_matrix_scanner_pkg::*;
(
  input  logic [SEG_W-1:0]  segments,
  input  logic [LINE_W-1:0] line,
  output logic [BMP_W-1:0]  bits
);

  logic a, b, c, d, e, f, g;

  assign {a, b, c, d, e, f, g} = segments;

  // Corners light only when the adjoining horizontal bar is off, giving rounded glyphs.
  always_comb begin
    bits = '0;
    case (line)
      3'd0:    bits = {f & ~a, a, a, a, b & ~a};
      3'd1:    bits = {f, 3'b000, b};
      3'd2:    bits = {(f | e) & ~g, g, g, g, (b | c) & ~g};
      3'd3:    bits = {e, 3'b000, c};
      3'd4:    bits = {e & ~d, d, d, d, c & ~d};
      default: bits = '0;
    endcase
  end

endmodule

// File: rtl/digit_matrix_scanner.sv
// Scans a frame of seven-segment digits onto a dot-matrix via serial row shift + latch.
// Line period 1 + 2*DIV*(6*DIGITS-1) + 1 + DWELL cycles; no backpressure, load is a strobe.
module digit_matrix_scanner
  import digit_matrix_scanner_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int LINES  = 5,
  parameter int DIV    = 2,
  parameter int DWELL  = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [SEG_W*DIGITS-1:0] seg_in,
  output logic                    pending,
  output logic                    row_data,
  output logic                    shift_clk,
  output logic                    row_latch,
  output logic [LINE_W-1:0]       row_sel
);

  localparam int DIG_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_MAX = (DIV > DWELL) ? DIV : DWELL;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [DIG_W-1:0]  LAST_DIG  = DIG_W'(DIGITS - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);
  localparam logic [CNT_W-1:0]  DIV_END   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  DWELL_END = CNT_W'(DWELL - 1);

  state_e                          state_q, state_d;
  logic [DIGITS-1:0][SEG_W-1:0]    shadow_q, shadow_d;
  logic [DIGITS-1:0][SEG_W-1:0]    display_q, display_d;
  logic                            pending_q, pending_d;
  logic [LINE_W-1:0]               line_q, line_d;
  logic [DIG_W-1:0]                digit_q, digit_d;
  logic [2:0]                      bit_q, bit_d;
  logic                            gap_q, gap_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            row_data_q, row_data_d;
  logic                            shift_clk_q, shift_clk_d;
  logic                            row_latch_q, row_latch_d;
  logic [LINE_W-1:0]               row_sel_q, row_sel_d;

  logic [DIG_W-1:0] adv_digit, cur_digit;
  logic [2:0]       adv_bit, cur_bit;
  logic             adv_gap, cur_gap, line_done;
  logic [SEG_W-1:0] cur_seg;
  logic [BMP_W-1:0] bitmap;

  // Next stream position after the current bit; only consumed at the end of SHIFT_HI.
  always_comb begin
    adv_digit = digit_q;
    adv_bit   = bit_q;
    adv_gap   = gap_q;
    line_done = 1'b0;
    if (gap_q) begin
      adv_gap   = 1'b0;
      adv_digit = digit_q - 1'b1;
      adv_bit   = 3'd4;
    end else if (bit_q != 3'd0) begin
      adv_bit = bit_q - 1'b1;
    end else if (digit_q == '0) begin
      line_done = 1'b1;
    end else begin
      adv_gap = 1'b1;
    end
  end

  assign cur_digit = (state_q == ST_SHIFT_HI) ? adv_digit : digit_q;
  assign cur_bit   = (state_q == ST_SHIFT_HI) ? adv_bit   : bit_q;
  assign cur_gap   = (state_q == ST_SHIFT_HI) ? adv_gap   : gap_q;
  assign cur_seg   = display_q[cur_digit];

  segments_to_bitmap u_s2b (
    .segments (cur_seg),
    .line     (line_q),
    .bits     (bitmap)
  );

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    display_d  = display_q;
    pending_d  = pending_q;
    line_d     = line_q;
    digit_d    = digit_q;
    bit_d      = bit_q;
    gap_d      = gap_q;
    cnt_d      = cnt_q;
    row_data_d = row_data_q;
    row_sel_d  = row_sel_q;

    if (load) begin
      shadow_d  = seg_in;
      pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_SETUP;
          line_d  = '0;
        end
      end
      ST_SETUP: begin
        state_d = ST_SHIFT_LO;
        cnt_d   = '0;
      end
      ST_SHIFT_LO: begin
        if (cnt_q == DIV_END) begin
          state_d = ST_SHIFT_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHIFT_HI: begin
        if (cnt_q == DIV_END) begin
          cnt_d   = '0;
          digit_d = adv_digit;
          bit_d   = adv_bit;
          gap_d   = adv_gap;
          state_d = line_done ? ST_LATCH : ST_SHIFT_LO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LATCH: begin
        state_d = ST_DWELL;
        cnt_d   = '0;
      end
      ST_DWELL: begin
        if (cnt_q == DWELL_END) begin
          line_d  = (line_q == LAST_LINE) ? '0 : line_q + 1'b1;
          state_d = en ? ST_SETUP : ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame swap only at the top of line 0 so a frame never mixes old and new digits.
    if (state_d == ST_SETUP) begin
      digit_d = LAST_DIG;
      bit_d   = 3'd4;
      gap_d   = 1'b0;
      if (line_d == '0) begin
        display_d = shadow_q;
        if (!load) pending_d = 1'b0;
      end
    end

    if (state_d == ST_SHIFT_LO && state_q != ST_SHIFT_LO)
      row_data_d = cur_gap ? 1'b0 : bitmap[cur_bit];
    if (state_d == ST_IDLE)
      row_data_d = 1'b0;
    if (state_d == ST_LATCH)
      row_sel_d = line_q;

    shift_clk_d = (state_d == ST_SHIFT_HI);
    row_latch_d = (state_d == ST_LATCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      display_q   <= '0;
      pending_q   <= 1'b0;
      line_q      <= '0;
      digit_q     <= '0;
      bit_q       <= '0;
      gap_q       <= 1'b0;
      cnt_q       <= '0;
      row_data_q  <= 1'b0;
      shift_clk_q <= 1'b0;
      row_latch_q <= 1'b0;
      row_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      display_q   <= display_d;
      pending_q   <= pending_d;
      line_q      <= line_d;
      digit_q     <= digit_d;
      bit_q       <= bit_d;
      gap_q       <= gap_d;
      cnt_q       <= cnt_d;
      row_data_q  <= row_data_d;
      shift_clk_q <= shift_clk_d;
      row_latch_q <= row_latch_d;
      row_sel_q   <= row_sel_d;
    end
  end

  assign pending   = pending_q;
  assign row_data  = row_data_q;
  assign shift_clk = shift_clk_q;
  assign row_latch = row_latch_q;
  assign row_sel   = row_sel_q;

endmodule

// File: tb/tb_digit_matrix_scanner.sv
// Bench for digit_matrix_scanner at default parameters: captures every shifted line,
// scoreboards it on row_latch against glyph-table expectations, and times the scan.
module tb_digit_matrix_scanner;

  localparam int DIGITS = 4;
  localparam int LINES  = 5;
  localparam int DIV    = 2;
  localparam int DWELL  = 1000;
  localparam int NBITS  = 6 * DIGITS - 1;
  localparam int LINE_PERIOD = 1 + 2 * DIV * NBITS + 1 + DWELL;

  typedef struct packed {
    logic [6:0]      seg;
    logic [4:0][4:0] rows;   // rows[L] = pixels of line L, bit 4 leftmost
  } glyph_t;

  typedef struct packed {
    logic [NBITS-1:0] bits;
    logic [2:0]       sel;
  } exp_t;

  logic                  clk;
  logic                  rst_n;
  logic                  en;
  logic                  load;
  logic [7*DIGITS-1:0]   seg_in;
  logic                  pending;
  logic                  row_data;
  logic                  shift_clk;
  logic                  row_latch;
  logic [2:0]            row_sel;

  glyph_t tbl [3];
  exp_t   exp_q [$];

  int errors = 0;
  int checks = 0;
  int latch_cnt = 0;
  int cyc = 0;

  logic             prev_sc = 1'b0;
  int               hi_run = 0;
  int               lo_run = 0;
  int               bitcnt = 0;
  logic [NBITS-1:0] shreg = '0;
  int               last_latch = 0;
  logic             have_last = 1'b0;

  digit_matrix_scanner #(
    .DIGITS (DIGITS),
    .LINES  (LINES),
    .DIV    (DIV),
    .DWELL  (DWELL)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .seg_in    (seg_in),
    .pending   (pending),
    .row_data  (row_data),
    .shift_clk (shift_clk),
    .row_latch (row_latch),
    .row_sel   (row_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [7*DIGITS-1:0] seg_word(input logic [DIGITS-1:0][1:0] fr);
    logic [7*DIGITS-1:0] w;
    w = '0;
    for (int d = 0; d < DIGITS; d++) w[7*d +: 7] = tbl[fr[d]].seg;
    return w;
  endfunction

  function automatic logic [NBITS-1:0] exp_row(input logic [DIGITS-1:0][1:0] fr, input int l);
    logic [NBITS-1:0] r;
    r = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      r = {r[NBITS-6:0], tbl[fr[d]].rows[l]};
      if (d > 0) r = {r[NBITS-2:0], 1'b0};
    end
    return r;
  endfunction

  task automatic push_frame(input logic [DIGITS-1:0][1:0] fr, input int nlines);
    exp_t e;
    for (int l = 0; l < nlines; l++) begin
      e.bits = exp_row(fr, l);
      e.sel  = 3'(l);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_latch(input int n, input int budget);
    int k;
    k = 0;
    while (latch_cnt < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check($sformatf("wait_latch_%0d", n), 32'(latch_cnt >= n), 1);
  endtask

  // Line monitor: shift-register model plus phase-length and latch-period checks.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      prev_sc   = 1'b0;
      hi_run    = 0;
      lo_run    = 0;
      bitcnt    = 0;
      shreg     = '0;
      have_last = 1'b0;
    end else begin
      if (shift_clk && !prev_sc) begin
        if (bitcnt > 0) check("shift_lo_phase", 32'(lo_run), DIV);
        lo_run = 0;
        shreg  = {shreg[NBITS-2:0], row_data};
        bitcnt++;
      end
      if (!shift_clk && prev_sc) begin
        check("shift_hi_phase", 32'(hi_run), DIV);
        hi_run = 0;
      end
      if (shift_clk) hi_run++;
      else           lo_run++;
      if (row_latch) begin
        latch_cnt++;
        check("bits_per_line", 32'(bitcnt), NBITS);
        check("latch_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check($sformatf("row_bits_l%0d", latch_cnt), 32'(shreg), 32'(e.bits));
          check($sformatf("row_sel_l%0d", latch_cnt), 32'(row_sel), 32'(e.sel));
        end
        if (have_last) check("line_period", 32'(cyc - last_latch), LINE_PERIOD);
        last_latch = cyc;
        have_last  = 1'b1;
        bitcnt     = 0;
        shreg      = '0;
      end
      prev_sc = shift_clk;
    end
  end

  initial begin
    logic [DIGITS-1:0][1:0] fr_blank, fr_a, fr_b, fr_c;
    int cnt;
    logic got;

    tbl[0] = '{seg: 7'b0000000, rows: {5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000}};
    tbl[1] = '{seg: 7'b0110000, rows: {5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001}};
    tbl[2] = '{seg: 7'b1111111, rows: {5'b01110, 5'b10001, 5'b01110, 5'b10001, 5'b01110}};

    fr_blank = '0;
    fr_a     = {2'd2, 2'd1, 2'd0, 2'd2};
    fr_b     = {2'd2, 2'd2, 2'd2, 2'd2};
    fr_c     = {2'd1, 2'd2, 2'd2, 2'd0};

    rst_n  = 1'b1;
    en     = 1'b1;
    load   = 1'b0;
    seg_in = '0;
    #1 rst_n = 1'b0;

    // Held in reset with en high: everything quiet.
    repeat (3) @(negedge clk);
    check("rst_pending",   32'(pending),   0);
    check("rst_row_data",  32'(row_data),  0);
    check("rst_shift_clk", 32'(shift_clk), 0);
    check("rst_row_latch", 32'(row_latch), 0);
    check("rst_row_sel",   32'(row_sel),   0);

    // Load lands in the same cycle as the first line-0 SETUP: frame 0 stays blank.
    push_frame(fr_blank, LINES);
    push_frame(fr_a, LINES);
    rst_n  = 1'b1;
    load   = 1'b1;
    seg_in = seg_word(fr_a);
    @(negedge clk);
    load = 1'b0;
    check("pending_after_setup_load", 32'(pending), 1);
    cnt = 1;
    while (!shift_clk && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("first_rise_cycles", 32'(cnt), 1 + DIV + 1);

    wait_latch(6, 8000);
    check("pending_applied_frame1", 32'(pending), 0);

    // Two loads during line 2: old frame continues, only the last load shows next frame.
    wait_latch(8, 4000);
    repeat (10) @(negedge clk);
    load   = 1'b1;
    seg_in = seg_word(fr_b);
    @(negedge clk);
    load = 1'b0;
    check("pending_after_load_b", 32'(pending), 1);
    repeat (50) @(negedge clk);
    load   = 1'b1;
    seg_in = seg_word(fr_c);
    @(negedge clk);
    load   = 1'b0;
    seg_in = '0;
    push_frame(fr_c, 4);
    check("pending_after_load_c", 32'(pending), 1);

    wait_latch(10, 4000);
    check("pending_held_to_frame_end", 32'(pending), 1);
    wait_latch(11, 2000);
    check("pending_cleared_frame2", 32'(pending), 0);

    // Drop en mid-shift of line 3: line still latches and dwells, then IDLE.
    wait_latch(13, 4000);
    cnt = 0;
    while (!shift_clk && cnt < 1200) begin
      @(negedge clk); #1;
      cnt++;
    end
    check("line3_shift_seen", 32'(shift_clk), 1);
    en = 1'b0;
    wait_latch(14, 2000);
    repeat (1200) @(negedge clk);
    #1;
    check("idle_latch_count", 32'(latch_cnt), 14);
    check("idle_row_sel",     32'(row_sel), 3);
    check("idle_shift_clk",   32'(shift_clk), 0);
    check("idle_row_data",    32'(row_data), 0);
    check("idle_queue_empty", 32'(exp_q.size()), 0);

    // Restart, then hit reset while shift_clk and row_data are both high.
    en  = 1'b1;
    got = 1'b0;
    cnt = 0;
    while (!got && cnt < 300) begin
      @(negedge clk); #1;
      got = shift_clk && row_data;
      cnt++;
    end
    check("restart_shift_one", 32'(got), 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_shift_clk", 32'(shift_clk), 0);
    check("mid_rst_row_data",  32'(row_data), 0);
    check("mid_rst_row_latch", 32'(row_latch), 0);
    check("mid_rst_row_sel",   32'(row_sel), 0);
    check("mid_rst_pending",   32'(pending), 0);
    repeat (3) @(negedge clk);
    #1;
    check("rst_no_latch", 32'(latch_cnt), 14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
